// File: rtl/ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe
//   Registered EX->MEM boundary for one issue lane, sitting directly after the
//   ALU. Ops are held in a 2-entry skid buffer (MAIN drives mem_o_*, SKID
//   absorbs the op that was already in flight when MEM stalled), so MEM
//   back-pressure never drops an op and ex_o_ready is a pure register output.
//   A jr (ex_i_change_pc) accepted from EX produces a one-cycle registered
//   redirect pulse towards fetch.
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_flush              kill all buffered ops and any op offered this cycle
//   ex_i_valid/ex_o_ready
//                        EX-side handshake; ex_i_* carry the op fields
//   ex_i_alu_pc          jr target, only used for the redirect
//   mem_o_valid/mem_i_ready
//                        MEM-side handshake; mem_o_* carry the MAIN entry
//   o_redirect           one-cycle pulse: fetch must jump to o_redirect_pc
// ---------------------------------------------------------------------------
module ex_mem_pipe #(
  parameter int DWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int RA_WIDTH = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  // EX side
  input  logic                ex_i_valid,
  output logic                ex_o_ready,
  input  logic [DWIDTH-1:0]   ex_i_alu_value,
  input  logic [PC_WIDTH-1:0] ex_i_alu_pc,
  input  logic                ex_i_change_pc,
  input  logic [PC_WIDTH-1:0] ex_i_pc,
  input  logic [RA_WIDTH-1:0] ex_i_rd_addr,
  input  logic                ex_i_reg_write,
  input  logic                ex_i_mem_read,
  input  logic                ex_i_mem_write,
  input  logic [DWIDTH-1:0]   ex_i_store_data,
  // MEM side
  output logic                mem_o_valid,
  input  logic                mem_i_ready,
  output logic [DWIDTH-1:0]   mem_o_alu_value,
  output logic [PC_WIDTH-1:0] mem_o_pc,
  output logic [RA_WIDTH-1:0] mem_o_rd_addr,
  output logic                mem_o_reg_write,
  output logic                mem_o_mem_read,
  output logic                mem_o_mem_write,
  output logic [DWIDTH-1:0]   mem_o_store_data,
  // Fetch redirect
  output logic                o_redirect,
  output logic [PC_WIDTH-1:0] o_redirect_pc
);

  typedef struct packed {
    logic [DWIDTH-1:0]   alu_value;
    logic [PC_WIDTH-1:0] pc;
    logic [RA_WIDTH-1:0] rd_addr;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [DWIDTH-1:0]   store_data;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  entry_t              main_q, main_d;
  entry_t              skid_q, skid_d;
  logic                ready_q, ready_d;
  logic                redirect_q, redirect_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  entry_t in_entry;
  logic   accept;
  logic   drain;

  assign in_entry.alu_value  = ex_i_alu_value;
  assign in_entry.pc         = ex_i_pc;
  assign in_entry.rd_addr    = ex_i_rd_addr;
  assign in_entry.reg_write  = ex_i_reg_write;
  assign in_entry.mem_read   = ex_i_mem_read;
  assign in_entry.mem_write  = ex_i_mem_write;
  assign in_entry.store_data = ex_i_store_data;

  // Both handshakes depend only on registered state on our side, so there
  // is no combinational path from mem_i_ready to ex_o_ready.
  assign accept = ex_i_valid & ready_q;
  assign drain  = (state_q != S_EMPTY) & mem_i_ready;

  always_comb begin
    state_d       = state_q;
    main_d        = main_q;
    skid_d        = skid_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        case ({accept, drain})
          2'b10: begin
            skid_d  = in_entry;
            state_d = S_FULL;
          end
          2'b01:   state_d = S_EMPTY;
          2'b11:   main_d  = in_entry;
          default: state_d = S_ONE;
        endcase
      end
      S_FULL: begin
        // ready_q is low here, so only a drain can happen.
        if (drain) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (accept && ex_i_change_pc) begin
      redirect_d    = 1'b1;
      redirect_pc_d = ex_i_alu_pc;
    end

    // Flush wins over everything computed above: the buffer empties, an op
    // accepted this cycle is dropped and its redirect is never issued. Data
    // in the entries is left as-is since it is invalid from here on.
    if (i_flush) begin
      state_d       = S_EMPTY;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
    end
  end

  assign ready_d = (state_d != S_FULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      ready_q       <= 1'b1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      ready_q       <= ready_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign ex_o_ready       = ready_q;
  assign mem_o_valid      = (state_q != S_EMPTY);
  assign mem_o_alu_value  = main_q.alu_value;
  assign mem_o_pc         = main_q.pc;
  assign mem_o_rd_addr    = main_q.rd_addr;
  assign mem_o_reg_write  = main_q.reg_write;
  assign mem_o_mem_read   = main_q.mem_read;
  assign mem_o_mem_write  = main_q.mem_write;
  assign mem_o_store_data = main_q.store_data;
  assign o_redirect       = redirect_q;
  assign o_redirect_pc    = redirect_pc_q;

endmodule
